// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the debug register dumper and its UART.
package sm_regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETADDR,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT
    } state_t;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LINE_LEN = 13;
    localparam int unsigned FRAME_W  = 10;

    localparam logic [CHAR_W-1:0] ASCII_COLON = 8'h3A;
    localparam logic [CHAR_W-1:0] ASCII_CR    = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF    = 8'h0A;

    // 0-9 map to '0'-'9', 10-15 map to 'A'-'F' ('A' - 10 = 0x37).
    function automatic logic [CHAR_W-1:0] hex_ascii(input logic [3:0] nib);
        hex_ascii = (nib < 4'd10) ? (8'h30 + CHAR_W'(nib)) : (8'h37 + CHAR_W'(nib));
    endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// UART 8N1 transmitter: one frame per load, done marks the last stop-bit cycle.
module sm_uart_tx
    import sm_regdump_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CHAR_W-1:0] data,
    output logic              ready,
    output logic              done,
    output logic              tx
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_W - 1);

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   baud_cnt;
    logic [3:0]         bit_cnt;

    // The line is the LSB of the frame register; ones shift in behind the stop bit.
    assign tx = shreg[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ready) begin
                if (load) begin
                    shreg    <= {1'b1, data, 1'b0};
                    ready    <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            end else if (baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    ready <= 1'b1;
                end else begin
                    shreg   <= {1'b1, shreg[FRAME_W-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
                // Registered one cycle early so it lines up with the final stop-bit cycle.
                if (bit_cnt == BIT_LAST && baud_cnt == CNT_PRE) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sm_regdump.sv
// Walks the CPU debug read port and prints one "AA:DDDDDDDD\r\n" line per register over UART.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned REG_FIRST = 0,
    parameter int unsigned REG_LAST  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    output logic              tx,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(REG_FIRST);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(REG_LAST);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(LINE_LEN - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   shadow, shadow_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                busy_nxt;
    logic                load_c;
    logic [CHAR_W-1:0]   char_c;
    logic                uart_ready;
    logic                uart_done;

    // Character at position idx of the line for the given address and captured data.
    function automatic logic [CHAR_W-1:0] line_char(
        input logic [IDX_W-1:0]  i,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W-1:0] sh;
        sh = d << {i - IDX_W'(3), 2'b00};
        if (i == IDX_W'(0))       line_char = hex_ascii({3'b000, a[4]});
        else if (i == IDX_W'(1))  line_char = hex_ascii(a[3:0]);
        else if (i == IDX_W'(2))  line_char = ASCII_COLON;
        else if (i <= IDX_W'(10)) line_char = hex_ascii(sh[DATA_W-1 -: 4]);
        else if (i == IDX_W'(11)) line_char = ASCII_CR;
        else                      line_char = ASCII_LF;
    endfunction

    assign char_c = line_char(idx, regAddr, shadow);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            regAddr <= ADDR_FIRST;
            shadow  <= '0;
            idx     <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            regAddr <= addr_nxt;
            shadow  <= shadow_nxt;
            idx     <= idx_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = regAddr;
        shadow_nxt = shadow;
        idx_nxt    = idx;
        busy_nxt   = busy;
        load_c     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETADDR;
                    addr_nxt  = ADDR_FIRST;
                    busy_nxt  = 1'b1;
                end
            end
            ST_SETADDR: state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                shadow_nxt = regData;
                idx_nxt    = '0;
                state_nxt  = ST_SEND;
            end
            ST_SEND: begin
                if (uart_ready) begin
                    load_c    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (uart_done) begin
                    if (idx != IDX_LAST) begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = ST_SEND;
                    end else if (regAddr < ADDR_LAST) begin
                        addr_nxt  = regAddr + ADDR_W'(1);
                        state_nxt = ST_SETADDR;
                    end else begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sm_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load_c),
        .data (char_c),
        .ready(uart_ready),
        .done (uart_done),
        .tx   (tx)
    );

endmodule

// File: tb/tb_sm_regdump.sv
// Scoreboard bench for sm_regdump: expected characters/timing queued at stimulus, UART decoded by a monitor.
module tb_sm_regdump;

    localparam int unsigned BAUD     = 4;
    localparam int unsigned CHAR_CYC = 10 * BAUD + 1;
    localparam int unsigned LINE_CYC = 13 * CHAR_CYC + 2;
    localparam int unsigned WAIT_MAX = 40000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic [31:0] pert0;
    logic        tx0, tx1, busy0, busy1;
    logic        tx_m, busy_m;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  exp_q[$];
    int unsigned busy_q[$];
    int unsigned first_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data0  = {27'h0, addr0} ^ 32'hDEADBEEF ^ pert0;
    assign data1  = {27'h0, addr1} ^ 32'hDEADBEEF;
    assign tx_m   = tx0 & tx1;
    assign busy_m = busy0 | busy1;

    sm_regdump #(.BAUD_DIV(BAUD), .REG_FIRST(0), .REG_LAST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .regAddr(addr0),
        .regData(data0), .tx(tx0), .busy(busy0)
    );

    sm_regdump #(.BAUD_DIV(BAUD), .REG_FIRST(0), .REG_LAST(31)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .regAddr(addr1),
        .regData(data1), .tx(tx1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic push_line(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] t;
        exp_q.push_back(hexc(4'(a >> 4)));
        exp_q.push_back(hexc(a[3:0]));
        exp_q.push_back(8'h3A);
        for (int i = 7; i >= 0; i--) begin
            t = d >> (4 * i);
            exp_q.push_back(hexc(t[3:0]));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Expected output of a dump whose start is accepted at edge n; p1 disturbs lines after the first.
    task automatic push_dump(input int unsigned n, input int nlines, input logic [31:0] p1);
        first_q.push_back(n + 3);
        busy_q.push_back(nlines * LINE_CYC);
        for (int l = 0; l < nlines; l++)
            push_line(5'(l), ({27'h0, 5'(l)} ^ 32'hDEADBEEF) ^ ((l > 0) ? p1 : 32'h0));
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic start_dump(input int sel, input int nlines, input logic [31:0] p1,
                              input int width, output int unsigned n);
        n = cyc + 1;
        push_dump(n, nlines, p1);
        drive_start(sel, 1'b1);
        repeat (width) begin @(posedge clk); #1; end
        drive_start(sel, 1'b0);
        if (p1 != 32'h0) begin
            while (cyc < n + 3) begin @(posedge clk); #1; end
            pert0 = p1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy_m && t < WAIT_MAX) begin @(negedge clk); t++; end
        chk("idle_timeout", 32'(t < WAIT_MAX), 32'd1);
        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // UART decoder plus busy/first-bit/gap timing, checked against the queues.
    task automatic monitor();
        int         s = 0;
        int         gap = 0;
        int         nchar = 0;
        int         bcnt = 0;
        logic       in_frame = 1'b0;
        logic [8:0] bits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0; gap = 0; nchar = 0; bcnt = 0;
                exp_q.delete(); busy_q.delete(); first_q.delete();
            end else begin
                if (busy_m) begin
                    bcnt++;
                end else if (bcnt > 0) begin
                    if (busy_q.size() == 0) chk("busy_unexpected", 32'(bcnt), 32'd0);
                    else                    chk("busy_len", 32'(bcnt), busy_q.pop_front());
                    bcnt = 0;
                    nchar = 0;
                end
                if (in_frame) begin
                    if (s % BAUD == 0) bits[s / BAUD] = tx_m;
                    else               chk("bit_hold", 32'(tx_m), 32'(bits[s / BAUD]));
                    if (s == 9 * BAUD - 1) begin
                        in_frame = 1'b0;
                        gap = 0;
                        if (exp_q.size() == 0) chk("char_unexpected", 32'(bits[8:1]), 32'h100);
                        else                   chk("char", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                        nchar++;
                    end
                    s++;
                end else if (tx_m == 1'b0) begin
                    in_frame = 1'b1;
                    s = 1;
                    bits[0] = 1'b0;
                    if (nchar == 0) begin
                        if (first_q.size() == 0) chk("start_unexpected", cyc, 32'hFFFFFFFF);
                        else                     chk("first_low_cycle", cyc, first_q.pop_front());
                    end else begin
                        chk("idle_gap", 32'(gap), (nchar % 13 == 0) ? 32'(BAUD + 3) : 32'(BAUD + 1));
                    end
                end else begin
                    gap++;
                end
            end
        end
    endtask

    initial begin
        int unsigned n;
        logic [31:0] p;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; pert0 = 32'h0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx0", 32'(tx0), 32'd1);
        chk("rst_tx1", 32'(tx1), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_addr0", 32'(addr0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end

        // single two-line dump
        start_dump(0, 2, 32'h0, 1, n);
        wait_idle();

        // start re-pulsed while busy is ignored
        start_dump(0, 2, 32'h0, 1, n);
        repeat (300) begin @(posedge clk); #1; end
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        repeat (400) begin @(posedge clk); #1; end
        start0 = 1'b1; @(posedge clk); #1; start0 = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);
        chk("no_restart_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;

        // regData changes one cycle after CAPTURE: line 0 keeps the captured value
        p = $urandom | 32'h1;
        start_dump(0, 2, p, 1, n);
        wait_idle();
        pert0 = 32'h0;

        // randomized spacing, pulse width and disturbance
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
            p = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h10) : 32'h0;
            start_dump(0, 2, p, int'($urandom_range(1, 3)), n);
            wait_idle();
            pert0 = 32'h0;
        end

        // start held high: second dump accepted one cycle after returning to IDLE
        n = cyc + 1;
        push_dump(n, 2, 32'h0);
        push_dump(n + 2 * LINE_CYC + 1, 2, 32'h0);
        start0 = 1'b1;
        while (cyc < n + 2 * LINE_CYC + 2) begin @(posedge clk); #1; end
        start0 = 1'b0;
        wait_idle();

        // reset during the data bits of character 5, then a clean dump
        start_dump(0, 2, 32'h0, 1, n);
        while (cyc < n + 3 + 5 * CHAR_CYC + BAUD + 10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_tx", 32'(tx0), 32'd1);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_addr", 32'(addr0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start_dump(0, 2, 32'h0, 1, n);
        wait_idle();

        // full address range ends at 31 without wrapping
        start_dump(1, 32, 32'h0, 1, n);
        wait_idle();
        repeat (20) @(negedge clk);
        chk("full_addr_last", 32'(addr1), 32'd31);
        chk("full_busy", 32'(busy1), 32'd0);
        chk("full_tx_idle", 32'(tx1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
